// File: rtl/stream_demux_1xn_if.sv
// Stream bundle for the 1-to-N demux: one input stream and N shared-payload output channels.
// The slave modport is the demux's view; the master modport is the source/sink side.
interface stream_demux_1xn_if #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 4,
  parameter int ERR_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic [SEL_W-1:0]  in_sel;
  logic [N_OUT-1:0]  out_valid;
  logic [N_OUT-1:0]  out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [ERR_W-1:0]  err_cnt;

  modport slave (
    input  in_valid, in_data, in_last, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_last, err_cnt
  );

  modport master (
    output in_valid, in_data, in_last, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_last, err_cnt
  );
endinterface

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N packet demux: the channel is locked on the first beat of a packet.
// Packets addressed beyond N_OUT are swallowed whole and counted once in a saturating counter.
module stream_demux_1xn #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 4,
  parameter int ERR_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  stream_demux_1xn_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [DATA_W-1:0]  r_buf_data;
  logic               r_buf_last;
  logic [SEL_W-1:0]   r_buf_ch;
  logic               r_buf_valid;
  logic [SEL_W-1:0]   r_lock_ch;
  logic [ERR_W-1:0]   r_err_cnt;

  logic               w_drain;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_sel_ok;
  logic               w_load;
  logic [SEL_W-1:0]   w_load_ch;
  logic               w_drop_first;
  logic [N_OUT-1:0]   w_out_valid;

  // Only the ready bit of the buffered beat's channel matters.
  always_comb begin
    w_drain     = 1'b0;
    w_out_valid = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (r_buf_ch == SEL_W'(i)) begin
        w_out_valid[i] = r_buf_valid;
        w_drain        = r_buf_valid && bus.out_ready[i];
      end
    end
  end

  assign w_sel_ok   = {1'b0, bus.in_sel} < (SEL_W+1)'(N_OUT);
  assign w_in_ready = rst ? 1'b0 : ((r_state == DROP) ? 1'b1 : (!r_buf_valid || w_drain));
  assign w_accept   = bus.in_valid && w_in_ready;

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_ch    = r_lock_ch;
    w_drop_first = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_sel_ok) begin
            w_load    = 1'b1;
            w_load_ch = bus.in_sel;
            if (!bus.in_last) w_next_state = PKT;
          end else begin
            w_drop_first = 1'b1;
            if (!bus.in_last) w_next_state = DROP;
          end
        end
      end
      PKT: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (bus.in_last) w_next_state = IDLE;
        end
      end
      DROP: begin
        if (w_accept && bus.in_last) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // A load takes priority over a drain so a back-to-back beat replaces the drained one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_buf_data  <= '0;
      r_buf_last  <= 1'b0;
      r_buf_ch    <= '0;
      r_buf_valid <= 1'b0;
      r_lock_ch   <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_buf_data  <= bus.in_data;
        r_buf_last  <= bus.in_last;
        r_buf_ch    <= w_load_ch;
        r_buf_valid <= 1'b1;
        r_lock_ch   <= w_load_ch;
      end else if (w_drain) begin
        r_buf_valid <= 1'b0;
      end
      if (w_drop_first && (r_err_cnt != {ERR_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_buf_data;
  assign bus.out_last  = r_buf_last;
  assign bus.err_cnt   = r_err_cnt;

endmodule
